// File: rtl/layer_scheduler_pkg.sv
// Shared constants and types for the layer prefetch scheduler.
package layer_scheduler_pkg;

   localparam int LAYER_W = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREFILL = 2'd1,
      RUN     = 2'd2
   } state_t;

endpackage

// File: rtl/layer_scheduler_fifo.sv
// Register FIFO holding queued layers; pointers wrap modulo DEPTH (power of two).
module layer_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Head is read combinationally; the scheduler registers it on delivery.
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/layer_scheduler.sv
// Prefetch scheduler: keeps up to DEPTH generated layers queued and hands the
// oldest one to the blocks renderer on every consume.
module layer_scheduler #(
   parameter int DEPTH   = 4,
   parameter int LAYER_W = layer_scheduler_pkg::LAYER_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   game_start,
   input  logic                   consume,
   output logic                   gen_req,
   input  logic                   gen_valid,
   input  logic [LAYER_W-1:0]     gen_map,
   input  logic [LAYER_W-1:0]     gen_type,
   output logic                   load_layer,
   output logic [LAYER_W-1:0]     layer_map,
   output logic [LAYER_W-1:0]     block_type,
   output logic                   ready,
   output logic [$clog2(DEPTH):0] fill_count,
   output logic                   underrun
);

   import layer_scheduler_pkg::*;

   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t state;
   state_t state_next;

   logic                   pending;
   logic                   pending_kept;
   logic                   pending_next;
   logic                   discard;
   logic                   discard_next;
   logic                   accept;
   logic                   push;
   logic                   pop;
   logic                   underrun_hit;
   logic                   req_next;
   logic [CW-1:0]          count_next;
   logic [2*LAYER_W-1:0]   head;

   layer_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2*LAYER_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (game_start),
      .push  (push),
      .pop   (pop),
      .wdata ({gen_map, gen_type}),
      .rdata (head),
      .count (fill_count)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      if (game_start) begin
         state_next = PREFILL;
      end else if (state == PREFILL && count_next == FULL) begin
         state_next = RUN;
      end
   end

   // Output logic
   always_comb begin
      ready = (state == RUN);
   end

   // Queue control and request tracking; requests look at next-cycle state so a
   // freed slot or a dropped response re-arms gen_req on the following edge.
   always_comb begin
      accept       = gen_valid && pending && !game_start;
      pop          = consume && !game_start && state == RUN && fill_count != '0;
      underrun_hit = consume && !game_start && state == RUN && fill_count == '0;
      push         = accept && !discard && state != IDLE && (fill_count != FULL || pop);
      count_next   = game_start ? '0 : fill_count + CW'(push) - CW'(pop);

      // A response arriving together with game_start answers the stale request.
      if (game_start) begin
         pending_kept = pending && !gen_valid;
         discard_next = pending && !gen_valid;
      end else if (accept) begin
         pending_kept = 1'b0;
         discard_next = 1'b0;
      end else begin
         pending_kept = pending;
         discard_next = discard;
      end

      req_next     = state_next != IDLE && !pending_kept && !gen_req && count_next < FULL;
      pending_next = pending_kept || req_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending    <= 1'b0;
         discard    <= 1'b0;
         gen_req    <= 1'b0;
         load_layer <= 1'b0;
         layer_map  <= '0;
         block_type <= '0;
         underrun   <= 1'b0;
      end else begin
         pending    <= pending_next;
         discard    <= discard_next;
         gen_req    <= req_next;
         load_layer <= pop;
         if (pop) begin
            layer_map  <= head[2*LAYER_W-1:LAYER_W];
            block_type <= head[LAYER_W-1:0];
         end
         if (game_start) begin
            underrun <= 1'b0;
         end else if (underrun_hit) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule
